// File: rtl/pipe_hazard_ctrl.sv
// pipe_hazard_ctrl: RAW hazard detect, SRAM freeze/watchdog, branch flush.
// Ports: ID sources, EXE/MEM dests -> hazard, freeze, flush, mem_abort, err, stall_cnt.
module pipe_hazard_ctrl #(
   parameter int FWD_EN  = 1,
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [3:0]       src1,
   input  logic [3:0]       src2,
   input  logic             two_src,
   input  logic [3:0]       exe_dest,
   input  logic             exe_wb_en,
   input  logic             exe_mem_r_en,
   input  logic [3:0]       mem_dest,
   input  logic             mem_wb_en,
   input  logic             branch_taken,
   input  logic             mem_req,
   input  logic             sram_ready,
   output logic             hazard,
   output logic             freeze,
   output logic             flush,
   output logic             mem_abort,
   output logic             err,
   output logic [CNT_W-1:0] stall_cnt
);

   localparam int WD_W = $clog2(TIMEOUT) + 1;
   localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      ABORT    = 2'd2
   } state_t;

   state_t          state;
   logic [WD_W-1:0] wdog;

   logic exe_hit;
   logic mem_hit;
   logic raw;
   logic stall;

   // Source match against a writer; src2 only counts when ID reads it.
   assign exe_hit = exe_wb_en &
                    ((src1 == exe_dest) |
                     (two_src & (src2 == exe_dest)));

   assign mem_hit = mem_wb_en &
                    ((src1 == mem_dest) |
                     (two_src & (src2 == mem_dest)));

   // With forwarding only a load in EXE cannot be bypassed in time.
   assign raw = (FWD_EN != 0) ? (exe_hit & exe_mem_r_en)
                              : (exe_hit | mem_hit);

   // Held reset forces every combinational control low at once.
   always_comb begin
      freeze    = 1'b0;
      flush     = 1'b0;
      hazard    = 1'b0;
      mem_abort = 1'b0;
      if (rst) begin
         unique case (state)
            IDLE:     freeze = mem_req & ~sram_ready;
            MEM_WAIT: freeze = ~sram_ready;
            default:  freeze = 1'b0;
         endcase
         mem_abort = (state == ABORT);
         flush     = branch_taken & ~freeze;
         hazard    = raw & ~freeze & ~branch_taken;
      end
   end

   assign stall = hazard | freeze;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= IDLE;
         wdog      <= '0;
         err       <= 1'b0;
         stall_cnt <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (mem_req & ~sram_ready) begin
                  state <= MEM_WAIT;
                  wdog  <= WD_W'(1);
               end
            end
            // mem_req is ignored here: a dropped request still waits.
            MEM_WAIT: begin
               if (sram_ready) begin
                  state <= IDLE;
                  wdog  <= '0;
               end else if (wdog == WD_LAST) begin
                  state <= ABORT;
               end else begin
                  wdog <= wdog + WD_W'(1);
               end
            end
            ABORT: begin
               state <= IDLE;
               wdog  <= '0;
               err   <= 1'b1;
            end
            default: begin
               state <= IDLE;
               wdog  <= '0;
            end
         endcase
         if (stall && (stall_cnt != '1))
            stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// tb_pipe_hazard_ctrl: directed vectors and corner sequences for pipe_hazard_ctrl.
// Two instances: forwarding (FWD_EN=1) and no forwarding (FWD_EN=0).
module tb_pipe_hazard_ctrl;

   localparam int CW = 4;
   localparam logic [CW-1:0] SAT = '1;

   logic clk = 1'b0;
   logic rst;
   logic [3:0] src1, src2, exe_dest, mem_dest;
   logic two_src, exe_wb_en, exe_mem_r_en, mem_wb_en;
   logic branch_taken, mem_req, sram_ready;

   logic hz_f, fz_f, fl_f, ab_f, er_f;
   logic hz_n, fz_n, fl_n, ab_n, er_n;
   logic [CW-1:0] cnt_f, cnt_n;

   int total = 0;
   int passed = 0;
   int exp_cf, exp_cn;

   always #5 clk = ~clk;

   pipe_hazard_ctrl #(.FWD_EN(1), .TIMEOUT(4), .CNT_W(CW)) u_fwd (
      .clk(clk), .rst(rst),
      .src1(src1), .src2(src2), .two_src(two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken),
      .mem_req(mem_req), .sram_ready(sram_ready),
      .hazard(hz_f), .freeze(fz_f), .flush(fl_f),
      .mem_abort(ab_f), .err(er_f), .stall_cnt(cnt_f)
   );

   pipe_hazard_ctrl #(.FWD_EN(0), .TIMEOUT(4), .CNT_W(CW)) u_nofwd (
      .clk(clk), .rst(rst),
      .src1(src1), .src2(src2), .two_src(two_src),
      .exe_dest(exe_dest), .exe_wb_en(exe_wb_en),
      .exe_mem_r_en(exe_mem_r_en),
      .mem_dest(mem_dest), .mem_wb_en(mem_wb_en),
      .branch_taken(branch_taken),
      .mem_req(mem_req), .sram_ready(sram_ready),
      .hazard(hz_n), .freeze(fz_n), .flush(fl_n),
      .mem_abort(ab_n), .err(er_n), .stall_cnt(cnt_n)
   );

   typedef struct {
      logic [3:0] s1, s2;
      logic       two;
      logic [3:0] ed;
      logic       ewb, eld;
      logic [3:0] md;
      logic       mwb, br, mreq, rdy;
      logic       hf, hn, frz, fl;
   } vec_t;

   vec_t tbl[13];

   function automatic vec_t mk(
      input logic [3:0] s1, input logic [3:0] s2, input logic two,
      input logic [3:0] ed, input logic ewb, input logic eld,
      input logic [3:0] md, input logic mwb, input logic br,
      input logic mreq, input logic rdy,
      input logic hf, input logic hn, input logic frz, input logic fl);
      vec_t v;
      v.s1 = s1; v.s2 = s2; v.two = two;
      v.ed = ed; v.ewb = ewb; v.eld = eld;
      v.md = md; v.mwb = mwb; v.br = br;
      v.mreq = mreq; v.rdy = rdy;
      v.hf = hf; v.hn = hn; v.frz = frz; v.fl = fl;
      return v;
   endfunction

   task automatic chk(input string name, input int act, input int exp);
      total++;
      if (act == exp) passed++;
      else $display("FAIL %s: got %0d expected %0d", name, act, exp);
   endtask

   task automatic idle_in();
      src1 = 0; src2 = 0; two_src = 0;
      exe_dest = 0; exe_wb_en = 0; exe_mem_r_en = 0;
      mem_dest = 0; mem_wb_en = 0;
      branch_taken = 0; mem_req = 0; sram_ready = 0;
   endtask

   task automatic apply(input vec_t v);
      src1 = v.s1; src2 = v.s2; two_src = v.two;
      exe_dest = v.ed; exe_wb_en = v.ewb; exe_mem_r_en = v.eld;
      mem_dest = v.md; mem_wb_en = v.mwb;
      branch_taken = v.br; mem_req = v.mreq; sram_ready = v.rdy;
   endtask

   // Ends 1 time unit after a rising edge with reset released.
   task automatic do_reset();
      idle_in();
      @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      @(posedge clk);
      #1;
      exp_cf = 0;
      exp_cn = 0;
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   initial begin
      tbl[0]  = mk(0,0,0, 0,0,0, 0,0, 0,0,0, 0,0,0,0);
      tbl[1]  = mk(3,0,0, 3,1,1, 0,0, 0,0,0, 1,1,0,0);
      tbl[2]  = mk(1,3,0, 3,1,1, 0,0, 0,0,0, 0,0,0,0);
      tbl[3]  = mk(1,3,1, 3,1,1, 0,0, 0,0,0, 1,1,0,0);
      tbl[4]  = mk(3,0,0, 3,1,0, 0,0, 0,0,0, 0,1,0,0);
      tbl[5]  = mk(3,0,0, 3,0,1, 0,0, 0,0,0, 0,0,0,0);
      tbl[6]  = mk(1,5,1, 9,1,0, 5,1, 0,0,0, 0,1,0,0);
      tbl[7]  = mk(1,5,1, 9,1,0, 15,1, 0,0,0, 0,0,0,0);
      tbl[8]  = mk(5,0,0, 9,1,0, 5,0, 0,0,0, 0,0,0,0);
      tbl[9]  = mk(3,0,0, 3,1,1, 0,0, 1,0,0, 0,0,0,1);
      tbl[10] = mk(0,0,0, 0,0,0, 0,0, 1,0,0, 0,0,0,1);
      tbl[11] = mk(3,0,0, 3,1,1, 0,0, 0,1,1, 1,1,0,0);
      tbl[12] = mk(15,0,0, 15,1,1, 0,0, 0,0,0, 1,1,0,0);

      // Reset held with every input high.
      rst = 1'b0;
      src1 = '1; src2 = '1; two_src = 1;
      exe_dest = '1; exe_wb_en = 1; exe_mem_r_en = 1;
      mem_dest = '1; mem_wb_en = 1;
      branch_taken = 1; mem_req = 1; sram_ready = 1;
      repeat (2) @(posedge clk);
      #1;
      chk("rst_err", er_f, 0);
      chk("rst_cnt", cnt_f, 0);
      chk("rst_abort", ab_f, 0);
      chk("rst_cnt_n", cnt_n, 0);

      do_reset();

      foreach (tbl[i]) begin
         apply(tbl[i]);
         #1;
         chk($sformatf("v%0d_hz_f", i), hz_f, tbl[i].hf);
         chk($sformatf("v%0d_hz_n", i), hz_n, tbl[i].hn);
         chk($sformatf("v%0d_frz", i), fz_f, tbl[i].frz);
         chk($sformatf("v%0d_fl", i), fl_f, tbl[i].fl);
         chk($sformatf("v%0d_fl_n", i), fl_n, tbl[i].fl);
         if ((tbl[i].hf | tbl[i].frz) && exp_cf != 15) exp_cf++;
         if ((tbl[i].hn | tbl[i].frz) && exp_cn != 15) exp_cn++;
         tick();
         chk($sformatf("v%0d_cnt_f", i), cnt_f, exp_cf);
         chk($sformatf("v%0d_cnt_n", i), cnt_n, exp_cn);
      end

      // SRAM wait: three frozen cycles, released on ready.
      do_reset();
      mem_req = 1; sram_ready = 0;
      for (int c = 0; c < 3; c++) begin
         #1;
         chk($sformatf("wait%0d_frz", c), fz_f, 1);
         tick();
      end
      sram_ready = 1;
      #1;
      chk("wait_rdy_frz", fz_f, 0);
      tick();
      chk("wait_cnt", cnt_f, 3);
      mem_req = 0; sram_ready = 0;
      #1;
      chk("wait_idle_frz", fz_f, 0);
      chk("wait_idle_abort", ab_f, 0);

      // Watchdog timeout.
      do_reset();
      mem_req = 1; sram_ready = 0;
      for (int c = 0; c < 4; c++) begin
         #1;
         chk($sformatf("to%0d_frz", c), fz_f, 1);
         chk($sformatf("to%0d_abort", c), ab_f, 0);
         tick();
      end
      #1;
      chk("to_abort", ab_f, 1);
      chk("to_abort_frz", fz_f, 0);
      chk("to_abort_err", er_f, 0);
      tick();
      #1;
      chk("to_after_abort", ab_f, 0);
      chk("to_err", er_f, 1);
      chk("to_cnt", cnt_f, 4);
      chk("to_restart_frz", fz_f, 1);
      tick();
      sram_ready = 1;
      #1;
      chk("to_restart_rdy", fz_f, 0);
      tick();
      chk("to_err_sticky", er_f, 1);
      chk("to_cnt2", cnt_f, 5);

      // Dropped request holds MEM_WAIT; async reset then clears it.
      sram_ready = 0;
      tick();
      mem_req = 0;
      #1;
      chk("drop_frz", fz_f, 1);
      #2;
      rst = 1'b0;
      #1;
      chk("arst_frz", fz_f, 0);
      chk("arst_err", er_f, 0);
      chk("arst_cnt", cnt_f, 0);
      @(negedge clk);
      rst = 1'b1;
      tick();
      #1;
      chk("arst_idle_frz", fz_f, 0);

      // Branch during freeze, and branch over raw.
      do_reset();
      mem_req = 1; sram_ready = 0; branch_taken = 1;
      for (int c = 0; c < 2; c++) begin
         #1;
         chk($sformatf("brf%0d_fl", c), fl_f, 0);
         chk($sformatf("brf%0d_frz", c), fz_f, 1);
         tick();
      end
      sram_ready = 1;
      #1;
      chk("brf_release_fl", fl_f, 1);
      chk("brf_release_frz", fz_f, 0);
      tick();

      // Saturation of the stall counter.
      do_reset();
      apply(tbl[1]);
      repeat (20) tick();
      chk("sat_cnt_f", cnt_f, SAT);
      chk("sat_cnt_n", cnt_n, SAT);
      tick();
      chk("sat_hold", cnt_f, SAT);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
